// File: rtl/xbtn_ctrl.sv
// Push-button peripheral: 2-FF synchroniser, per-button debounce counter, sticky press
// and overrun flags with read-to-clear / write-1-to-clear access, and a registered irq.
module xbtn_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn,
    input  logic              sel,
    input  logic              we,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              irq
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

    logic [N_BTN-1:0] s1_q, s2_q;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] overrun_q, overrun_d;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] clr_pend, clr_ovr;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic             irq_q;
    logic             rd, wr;
    logic [DATA_W-1:0] rdata;

    assign rd = sel & ~we;
    assign wr = sel & we;

    // Count only while the synchronised level disagrees with the accepted level.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable_d & ~stable_q;

    always_comb begin
        clr_pend = '0;
        clr_ovr  = '0;
        if (rd) begin
            clr_pend = '1;
            clr_ovr  = '1;
        end else if (wr) begin
            clr_pend = data_in[N_BTN-1:0];
            clr_ovr  = data_in[16 +: N_BTN];
        end
    end

    // A press always wins over a same-cycle clear; overrun only flags a genuinely lost press.
    always_comb begin
        pending_d = press | (pending_q & ~clr_pend);
        overrun_d = (overrun_q & ~clr_ovr) | (press & pending_q & ~clr_pend);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_q     <= |pending_q;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        rdata              = '0;
        rdata[0 +: N_BTN]  = pending_q;
        rdata[8 +: N_BTN]  = stable_q;
        rdata[16 +: N_BTN] = overrun_q;
        data_out           = sel ? rdata : '0;
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_xbtn_ctrl.sv
// Bench for xbtn_ctrl: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a timestamp-based behavioural model.
module tb_xbtn_ctrl;

    localparam int DW  = 32;
    localparam int NB  = 4;
    localparam int DEB = 4;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn;
    logic          sel;
    logic          we;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          irq;

    int checks;
    int failures;

    xbtn_ctrl #(
        .DATA_W(DW),
        .N_BTN(NB),
        .DEB_CYCLES(DEB),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .sel(sel),
        .we(we),
        .data_in(data_in),
        .data_out(data_out),
        .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a button's accepted level follows the synchronised level once that level has
    // been continuously present (and different) for DEB sampled edges.
    logic [NB-1:0] m_s1, m_s2, m_stable, m_pend, m_ovr, m_prev;
    logic          m_irq;
    int            m_start [NB];
    int            edge_no;
    bit            armed;

    always @(posedge clk) begin
        logic [NB-1:0] press, nstable, clr_p, clr_o;
        logic [DW-1:0] exp_word;
        edge_no++;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_ovr = '0; m_irq = 1'b0;
            m_prev = '0;
            for (int i = 0; i < NB; i++) m_start[i] = edge_no + 1;
            armed = 1'b1;
        end else begin
            press   = '0;
            nstable = m_stable;
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] != m_prev[i]) m_start[i] = edge_no;
                m_prev[i] = m_s2[i];
                if (m_s2[i] != m_stable[i] && (edge_no - m_start[i] + 1) >= DEB) begin
                    nstable[i] = m_s2[i];
                    press[i]   = m_s2[i];
                end
            end
            clr_p = !sel ? '0 : (we ? data_in[NB-1:0] : '1);
            clr_o = !sel ? '0 : (we ? data_in[16 +: NB] : '1);
            m_irq    = |m_pend;
            m_ovr    = (m_ovr & ~clr_o) | (press & m_pend & ~clr_p);
            m_pend   = press | (m_pend & ~clr_p);
            m_stable = nstable;
            m_s2     = m_s1;
            m_s1     = btn;
        end
        #1;
        if (armed) begin
            exp_word = {8'h0, 4'h0, m_ovr, 4'h0, m_stable, 4'h0, m_pend};
            chk("model_data_out", data_out, sel ? exp_word : '0);
            chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_lit(input string name, input logic [31:0] exp);
        sel = 1'b1;
        we  = 1'b0;
        #1 chk(name, data_out, exp);
        cyc(1);
        sel = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; edge_no = 0; armed = 1'b0;
        btn = '0; sel = 1'b0; we = 1'b0; data_in = '0; rst = 1'b1;
        cyc(2);
        rst = 1'b0;

        // Idle read after reset
        sel = 1'b1;
        #1 chk("idle_read", data_out, 32'h0);
        chk("idle_irq", {31'd0, irq}, 32'd0);
        cyc(1);
        sel = 1'b0;

        // Clean press on btn[0]
        btn = 4'b0001;
        cyc(10);
        #1 chk("press0_irq", {31'd0, irq}, 32'd1);
        read_lit("press0_read", 32'h0000_0101);
        btn = 4'b0000;
        cyc(8);

        // Short glitch on btn[1] is rejected
        btn = 4'b0010;
        cyc(3);
        btn = 4'b0000;
        cyc(10);
        #1 chk("glitch_irq", {31'd0, irq}, 32'd0);
        read_lit("glitch_read", 32'h0);

        // Two presses on btn[2] without a read set overrun
        btn = 4'b0100;
        cyc(8);
        btn = 4'b0000;
        cyc(8);
        btn = 4'b0100;
        cyc(8);
        sel = 1'b1;
        #1 chk("overrun_read", data_out, 32'h0004_0404);
        cyc(1);
        #1 chk("second_read", data_out, 32'h0000_0400);
        cyc(1);
        sel = 1'b0;

        // Read lands on the same edge as btn[3]'s press pulse
        btn = 4'b1100;
        cyc(5);
        read_lit("coincident_read", 32'h0000_0400);
        read_lit("after_coincident", 32'h0000_0C08);

        // W1C on pending[0] with pending = 0011
        btn = 4'b0011;
        cyc(8);
        btn = 4'b0000;
        cyc(8);
        sel = 1'b1; we = 1'b1; data_in = 32'h0000_0001;
        cyc(1);
        we = 1'b0; data_in = '0;
        #1 chk("w1c_read", data_out, 32'h0000_0002);
        cyc(1);
        sel = 1'b0;

        // Reset in the middle of a debounce window
        btn = 4'b0001;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        #1 chk("post_rst_irq", {31'd0, irq}, 32'd0);
        read_lit("post_rst_read", 32'h0);
        cyc(10);
        read_lit("restart_read", 32'h0000_0101);
        btn = 4'b0000;
        cyc(8);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(11) == 0) btn[i] = ~btn[i];
            end
            sel     = ($urandom_range(3) == 0);
            we      = $urandom_range(1) == 1;
            data_in = $urandom;
            rst     = ($urandom_range(699) == 0);
            cyc(1);
        end
        rst = 1'b0; sel = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
